dm_copy_dma: RTL and testbench
==============================

# dm_copy_dma

Block-copy DMA engine that initiates read/write traffic on the 16-bit single-ported data memory interface. It copies `len` consecutive words from `src` to `dst` while the CPU leaves data memory idle, driving `addr`/`re`/`we`/`wrt_data` and consuming `rd_data`. It sits beside the MEM stage; a top-level mux grants it the data-memory port while `busy` is high.

## Interface
- No parameters: widths fixed to 16-bit address and data.
- `clk` input 1: system clock. Data memory acts on the falling edge; this block acts on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a transfer; sampled only in IDLE.
- `src` input 16: first source word address, latched on accepted `start`.
- `dst` input 16: first destination word address, latched on accepted `start`.
- `len` input 16: word count, latched on accepted `start`.
- `abort` input 1: synchronous cancel of a transfer in progress.
- `busy` output 1: high from the cycle after an accepted `start` until return to IDLE.
- `done` output 1: one-cycle pulse on normal completion.
- `remaining` output 16: words not yet written.
- `addr` output 16: data-memory word address, registered.
- `re` output 1: data-memory read enable, registered.
- `we` output 1: data-memory write enable, registered; never high together with `re`.
- `wrt_data` output 16: data-memory write data, registered.
- `rd_data` input 16: data-memory read data, valid after the falling edge of a cycle with `re` high.
- `fill`, `fill_val` (input 1, input 16): present only with `DM_DMA_FILL_EN`. See Configuration.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE, `start`=1, `len`≠0: latch `src`, `dst`, `len` into `sptr`, `dptr`, `remaining`. Go to RD with `addr`<=`src`, `re`<=1, `we`<=0.
- IDLE, `start`=1, `len`=0: go to DONE without any memory access.
- RD to WR at the next edge:
  - `wrt_data`<=`rd_data`, `addr`<=`dptr`, `re`<=0, `we`<=1.
  - `sptr`<=`sptr`+1.
- WR at the next edge:
  - `dptr`<=`dptr`+1, `remaining`<=`remaining`-1.
  - If `remaining`=1, go to DONE with `re`=`we`=0.
  - Otherwise go to RD with `addr`<=new `sptr`, `re`<=1.
- DONE: `done`=1 for one cycle, `busy` stays high. Next state is IDLE.
- Pointer arithmetic is modulo 2^16; `0xFFFF`+1 wraps to `0x0000`.
- Copy order is ascending. For overlapping regions with `dst`>`src`, source words are overwritten before they are read. This is defined behaviour, not an error.
- `start` while not IDLE is ignored.
- `abort` in RD or WR: next edge goes to IDLE with `re`=`we`=0. No `done` pulse. `remaining` holds its value.
  - An abort in WR suppresses the pointer and count update.
  - The write in that WR cycle still completes at its falling edge.
- `abort` in IDLE or DONE has no effect.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `remaining`=0, `addr`=0, `re`=0, `we`=0, `wrt_data`=0.
- All DM outputs change only on rising edges, so they are stable at the DM falling edge.
- Copy mode costs 2 cycles per word.
  - `start` sampled at edge 0; `re`=1 during cycle 1; `we`=1 during cycle 2.
  - For `len`=N, `done` is high during cycle 2N+1 and `busy` falls at edge 2N+2.
- `len`=0: `done` is high in cycle 1; `busy` is high only in cycle 1.
- `remaining` decrements at the rising edge that ends each WR cycle.

## Configuration
- `DM_DMA_FILL_EN` defined: ports `fill` and `fill_val` exist and are latched on `start`.
  - With `fill`=1, RD is skipped. Each word takes 1 WR cycle with `wrt_data`=`fill_val` and `addr`=`dptr`.
  - `re` stays 0 for the whole transfer. `len`=N gives `done` in cycle N+1.
- `DM_DMA_FILL_EN` undefined: the ports are absent and the block always copies.

## Test plan
- Reset mid-transfer: assert `rst_n`=0 in a WR cycle -> all outputs go to reset values immediately; the next `start` runs normally.
- Copy 4 words with mem[0x0100..0x0103]=`A1,B2,C3,D4`, `src`=0x0100, `dst`=0x0200 -> mem[0x0200..0x0203] holds the same values.
  - `done` is high in cycle 9.
  - `re`&`we` is never 1.
  - `remaining` steps 4,3,2,1,0.
- `len`=0 -> `done` in cycle 1; `re` and `we` stay 0.
- Wrap: `src`=0xFFFF, `dst`=0x0010, `len`=2 -> reads from 0xFFFF then 0x0000.
- Abort in the 2nd RD of a `len`=5 copy -> exactly 1 word written, `remaining`=4, no `done`, IDLE next cycle. Then `start` while `busy` is ignored.
- With `DM_DMA_FILL_EN`: `fill`=1, `fill_val`=0xBEEF, `dst`=0x0040, `len`=3 -> 0x0040..0x0042 = 0xBEEF, `re` never high, `done` in cycle 4.

Source files
------------

// File: rtl/dm_copy_dma.sv
`default_nettype none
// ============================================================================
// Module   : dm_copy_dma
// Purpose  : Block-copy DMA engine for the 16-bit single-ported data memory.
//            It copies len_i consecutive words from src_i to dst_i in
//            ascending order. Each copied word takes one RD cycle and one
//            WR cycle. While busy_o is high, a top-level mux gives this block
//            the data-memory port.
//            The data memory acts on the falling edge of clk_i. This block
//            acts on the rising edge, so every memory-side output is
//            registered and is stable at the memory's falling edge.
// Option   : DM_DMA_FILL_EN adds the fill_i/fill_val_i ports. With fill_i=1
//            the engine writes fill_val_i to every destination word. It
//            issues no reads and takes one cycle per word.
// Ports    : clk_i        system clock (rising edge)
//            rst_n_i      asynchronous active-low reset
//            start_i      one-cycle transfer request, honoured only in IDLE
//            src_i/dst_i  first source / destination word address
//            len_i        word count (0 gives an immediate done pulse)
//            abort_i      cancel the transfer in RD/WR; no done pulse
//            busy_o       high from the cycle after start until back in IDLE
//            done_o       one-cycle pulse on normal completion
//            remaining_o  words not yet written
//            addr_o/re_o/we_o/wrt_data_o  data-memory request (registered)
//            rd_data_i    data-memory read data, valid after falling edge
//            fill_i/fill_val_i  fill mode controls (DM_DMA_FILL_EN only)
// Revision : 1.0  initial release
// ============================================================================
module dm_copy_dma (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [15:0] src_i,
    input  logic [15:0] dst_i,
    input  logic [15:0] len_i,
    input  logic        abort_i,
`ifdef DM_DMA_FILL_EN
    input  logic        fill_i,
    input  logic [15:0] fill_val_i,
`endif
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] remaining_o,
    output logic [15:0] addr_o,
    output logic        re_o,
    output logic        we_o,
    output logic [15:0] wrt_data_o,
    input  logic [15:0] rd_data_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] sptr_q;
    logic [15:0] dptr_q;
    logic [15:0] remaining_q;
    logic [15:0] addr_q;
    logic [15:0] wrt_data_q;
    logic        re_q;
    logic        we_q;
    logic        busy_q;
    logic        done_q;

    // Incremented pointers and decremented count (pointer math wraps mod 2^16)
    logic [15:0] sptr_d;
    logic [15:0] dptr_d;
    logic [15:0] remaining_d;

    assign sptr_d      = sptr_q + 16'd1;
    assign dptr_d      = dptr_q + 16'd1;
    assign remaining_d = remaining_q - 16'd1;

    // Fill-mode controls. The default build ties them off, so the FSM
    // below is the same for both builds.
    logic        fill_req;   // fill requested along with start
    logic [15:0] fill_word;  // value for the first fill write
    logic        fill_mode;  // active transfer is a fill
    logic [15:0] fill_data;  // value for the later fill writes

`ifdef DM_DMA_FILL_EN
    logic        fill_q;
    logic [15:0] fill_val_q;

    assign fill_req  = fill_i;
    assign fill_word = fill_val_i;
    assign fill_mode = fill_q;
    assign fill_data = fill_val_q;
`else
    assign fill_req  = 1'b0;
    assign fill_word = 16'h0000;
    assign fill_mode = 1'b0;
    assign fill_data = 16'h0000;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            sptr_q      <= 16'h0000;
            dptr_q      <= 16'h0000;
            remaining_q <= 16'h0000;
            addr_q      <= 16'h0000;
            wrt_data_q  <= 16'h0000;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DM_DMA_FILL_EN
            fill_q      <= 1'b0;
            fill_val_q  <= 16'h0000;
`endif
        end else begin
            // done is a single-cycle pulse. It is set only on the edge
            // that enters DONE.
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (len_i == 16'd0) begin
                            // Zero-length transfer: report done, no memory traffic
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            sptr_q      <= src_i;
                            dptr_q      <= dst_i;
                            remaining_q <= len_i;
`ifdef DM_DMA_FILL_EN
                            fill_q      <= fill_i;
                            fill_val_q  <= fill_val_i;
`endif
                            if (fill_req) begin
                                // Fill goes straight to the first write
                                state_q    <= S_WR;
                                addr_q     <= dst_i;
                                wrt_data_q <= fill_word;
                                re_q       <= 1'b0;
                                we_q       <= 1'b1;
                            end else begin
                                state_q <= S_RD;
                                addr_q  <= src_i;
                                re_q    <= 1'b1;
                                we_q    <= 1'b0;
                            end
                        end
                    end
                end

                S_RD: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                    end else begin
                        // The memory returned the word at the falling edge of this cycle
                        state_q    <= S_WR;
                        wrt_data_q <= rd_data_i;
                        addr_q     <= dptr_q;
                        re_q       <= 1'b0;
                        we_q       <= 1'b1;
                        sptr_q     <= sptr_d;
                    end
                end

                S_WR: begin
                    if (abort_i) begin
                        // This cycle's write already completed at the falling
                        // edge. The pointers and count are left untouched.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                    end else begin
                        dptr_q      <= dptr_d;
                        remaining_q <= remaining_d;
                        if (remaining_q == 16'd1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            re_q    <= 1'b0;
                            we_q    <= 1'b0;
                        end else if (fill_mode) begin
                            state_q    <= S_WR;
                            addr_q     <= dptr_d;
                            wrt_data_q <= fill_data;
                            re_q       <= 1'b0;
                            we_q       <= 1'b1;
                        end else begin
                            // sptr_q already advanced in RD
                            state_q <= S_RD;
                            addr_q  <= sptr_q;
                            re_q    <= 1'b1;
                            we_q    <= 1'b0;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    re_q    <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign remaining_o = remaining_q;
    assign addr_o      = addr_q;
    assign re_o        = re_q;
    assign we_o        = we_q;
    assign wrt_data_o  = wrt_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_copy_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_copy_dma
// Purpose  : Directed self-checking bench for dm_copy_dma. It includes a
//            behavioural data memory that acts on the falling edge.
//            Define DM_DMA_FILL_EN to also run the fill-mode test.
// Revision : 1.0  initial release
// ============================================================================
module tb_dm_copy_dma;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] remaining;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [15:0] wrt_data;
    logic [15:0] rd_data;
`ifdef DM_DMA_FILL_EN
    logic        fill;
    logic [15:0] fill_val;
`endif

    logic [15:0] mem [0:65535];
    int          rem_log [0:63];
    int          n_checks;
    int          n_errors;

    dm_copy_dma u_dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .src_i       (src),
        .dst_i       (dst),
        .len_i       (len),
        .abort_i     (abort),
`ifdef DM_DMA_FILL_EN
        .fill_i      (fill),
        .fill_val_i  (fill_val),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .remaining_o (remaining),
        .addr_o      (addr),
        .re_o        (re),
        .we_o        (we),
        .wrt_data_o  (wrt_data),
        .rd_data_i   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: reads and writes happen on the falling edge
    always @(negedge clk) begin
        if (re) rd_data <= mem[addr];
        if (we) mem[addr] <= wrt_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one transfer. Cycle 1 is the cycle after the edge that samples start.
    // With retrig set, start stays high with different operands for the
    // next two edges. Those requests must be ignored.
    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            input bit retrig,
                            output int done_cyc, output int done_cnt, output int both,
                            output int re_n, output int we_n, output int end_cyc);
        int cyc;
        done_cyc = -1; done_cnt = 0; both = 0; re_n = 0; we_n = 0; end_cyc = -1;
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        if (retrig) begin
            src = 16'h0300; dst = 16'h0600; len = 16'd9;
        end else begin
            start = 1'b0;
        end
        cyc = 1;
        while (cyc < 64) begin
            rem_log[cyc] = int'(remaining);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (re && we) both++;
            if (re) re_n++;
            if (we) we_n++;
            if (!busy) begin
                end_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) start = 1'b0;
        end
        start = 1'b0;
        if (end_cyc < 0) check("xfer_timeout", 32'd1, 32'd0);
    endtask

    int dc, dn, bo, rn, wn, ec;

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 64; i++) rem_log[i] = -1;
        rd_data = 16'h0000;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        src = 16'h0000; dst = 16'h0000; len = 16'h0000;
`ifdef DM_DMA_FILL_EN
        fill = 1'b0; fill_val = 16'h0000;
`endif
        mem[16'h0100] = 16'h00A1; mem[16'h0101] = 16'h00B2;
        mem[16'h0102] = 16'h00C3; mem[16'h0103] = 16'h00D4;
        mem[16'hFFFF] = 16'h1111; mem[16'h0000] = 16'h2222;
        for (int i = 0; i < 5; i++) mem[16'h0300 + i] = 16'h5000 + 16'(i);

        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_remaining", {16'd0, remaining}, 32'd0);
        check("rst_addr", {16'd0, addr}, 32'd0);
        check("rst_re", {31'd0, re}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_wrt_data", {16'd0, wrt_data}, 32'd0);

        // Copy 4 words 0x0100 -> 0x0200
        run_xfer(16'h0100, 16'h0200, 16'd4, 1'b0, dc, dn, bo, rn, wn, ec);
        check("copy4_done_cyc", dc, 32'd9);
        check("copy4_done_cnt", dn, 32'd1);
        check("copy4_re_and_we", bo, 32'd0);
        check("copy4_reads", rn, 32'd4);
        check("copy4_writes", wn, 32'd4);
        check("copy4_busy_fall_cyc", ec, 32'd10);
        check("copy4_rem_c1", rem_log[1], 32'd4);
        check("copy4_rem_c3", rem_log[3], 32'd3);
        check("copy4_rem_c5", rem_log[5], 32'd2);
        check("copy4_rem_c7", rem_log[7], 32'd1);
        check("copy4_rem_c9", rem_log[9], 32'd0);
        check("copy4_m200", {16'd0, mem[16'h0200]}, 32'h00A1);
        check("copy4_m201", {16'd0, mem[16'h0201]}, 32'h00B2);
        check("copy4_m202", {16'd0, mem[16'h0202]}, 32'h00C3);
        check("copy4_m203", {16'd0, mem[16'h0203]}, 32'h00D4);
        check("copy4_m204", {16'd0, mem[16'h0204]}, 32'h0000);

        // Zero length
        run_xfer(16'h0100, 16'h0280, 16'd0, 1'b0, dc, dn, bo, rn, wn, ec);
        check("len0_done_cyc", dc, 32'd1);
        check("len0_busy_fall_cyc", ec, 32'd2);
        check("len0_reads", rn, 32'd0);
        check("len0_writes", wn, 32'd0);

        // Source pointer wraps 0xFFFF -> 0x0000
        run_xfer(16'hFFFF, 16'h0010, 16'd2, 1'b0, dc, dn, bo, rn, wn, ec);
        check("wrap_done_cyc", dc, 32'd5);
        check("wrap_m010", {16'd0, mem[16'h0010]}, 32'h1111);
        check("wrap_m011", {16'd0, mem[16'h0011]}, 32'h2222);

        // Abort in the second RD of a len=5 copy
        @(negedge clk);
        src = 16'h0300; dst = 16'h0400; len = 16'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;           // cycle 1: RD
        @(posedge clk); #1;                         // cycle 2: WR
        @(posedge clk); #1;                         // cycle 3: second RD
        check("abort_in_rd", {31'd0, re}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;           // cycle 4
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_re", {31'd0, re}, 32'd0);
        check("abort_we", {31'd0, we}, 32'd0);
        check("abort_remaining", {16'd0, remaining}, 32'd4);
        @(posedge clk); #1;
        check("abort_no_late_done", {31'd0, done}, 32'd0);
        check("abort_m400", {16'd0, mem[16'h0400]}, 32'h5000);
        check("abort_m401", {16'd0, mem[16'h0401]}, 32'h0000);

        // start held high while busy must be ignored
        run_xfer(16'h0100, 16'h0500, 16'd2, 1'b1, dc, dn, bo, rn, wn, ec);
        check("retrig_done_cyc", dc, 32'd5);
        check("retrig_writes", wn, 32'd2);
        check("retrig_m500", {16'd0, mem[16'h0500]}, 32'h00A1);
        check("retrig_m501", {16'd0, mem[16'h0501]}, 32'h00B2);
        check("retrig_m600", {16'd0, mem[16'h0600]}, 32'h0000);

        // Reset asserted during a WR cycle
        @(negedge clk);
        src = 16'h0100; dst = 16'h0800; len = 16'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;           // cycle 1: RD
        @(posedge clk); #1;                         // cycle 2: WR
        check("midrst_in_wr", {31'd0, we}, 32'd1);
        #2; rst_n = 1'b0; #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_we", {31'd0, we}, 32'd0);
        check("midrst_re", {31'd0, re}, 32'd0);
        check("midrst_addr", {16'd0, addr}, 32'd0);
        check("midrst_remaining", {16'd0, remaining}, 32'd0);
        check("midrst_wrt_data", {16'd0, wrt_data}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_xfer(16'h0100, 16'h0700, 16'd2, 1'b0, dc, dn, bo, rn, wn, ec);
        check("postrst_done_cyc", dc, 32'd5);
        check("postrst_m700", {16'd0, mem[16'h0700]}, 32'h00A1);
        check("postrst_m701", {16'd0, mem[16'h0701]}, 32'h00B2);

`ifdef DM_DMA_FILL_EN
        // Fill 3 words with 0xBEEF at 0x0040
        fill = 1'b1; fill_val = 16'hBEEF;
        run_xfer(16'h0100, 16'h0040, 16'd3, 1'b0, dc, dn, bo, rn, wn, ec);
        fill = 1'b0;
        check("fill_done_cyc", dc, 32'd4);
        check("fill_reads", rn, 32'd0);
        check("fill_writes", wn, 32'd3);
        check("fill_m040", {16'd0, mem[16'h0040]}, 32'hBEEF);
        check("fill_m041", {16'd0, mem[16'h0041]}, 32'hBEEF);
        check("fill_m042", {16'd0, mem[16'h0042]}, 32'hBEEF);
        check("fill_m043", {16'd0, mem[16'h0043]}, 32'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
